core_regs_sb: RTL

- Parametrised multi-port integer register file for the core, with an integrated write-scoreboard.
- NUM_RD combinational read ports serve core_id; two write ports serve core_ex and the load/writeback path.
- A per-register busy bit is set when an instruction with a destination issues and cleared at its writeback.
- Lets core_id detect RAW/WAW hazards without a separate hazard unit.

---
 rtl/core_regs_sb_if.sv | 33 +++
 rtl/core_regs_sb.sv | 108 ++++++++++
 2 files changed

// File: rtl/core_regs_sb_if.sv
// Bus bundle for the core_regs_sb register file: write ports, read ports and issue/scoreboard signals.
// The master side (the core) drives requests and the slave side (the register file) returns data and busy state.
interface core_regs_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                       we0_in;
  logic [ADDR_W-1:0]          waddr0_in;
  logic [DATA_W-1:0]          wdata0_in;
  logic                       we1_in;
  logic [ADDR_W-1:0]          waddr1_in;
  logic [DATA_W-1:0]          wdata1_in;
  logic [NUM_RD*ADDR_W-1:0]   raddr_in;
  logic [NUM_RD*DATA_W-1:0]   rdata_out;
  logic [NUM_RD-1:0]          rbusy_out;
  logic                       issue_in;
  logic [ADDR_W-1:0]          issue_addr_in;
  logic                       issue_ready_out;
  logic [ADDR_W:0]            busy_cnt_out;

  modport master (
    output we0_in, waddr0_in, wdata0_in, we1_in, waddr1_in, wdata1_in,
    output raddr_in, issue_in, issue_addr_in,
    input  rdata_out, rbusy_out, issue_ready_out, busy_cnt_out
  );

  modport slave (
    input  we0_in, waddr0_in, wdata0_in, we1_in, waddr1_in, wdata1_in,
    input  raddr_in, issue_in, issue_addr_in,
    output rdata_out, rbusy_out, issue_ready_out, busy_cnt_out
  );
endinterface

// File: rtl/core_regs_sb.sv
// Multi-port integer register file with a per-register write scoreboard for RAW/WAW hazard detection.
// Optional same-cycle write-to-read bypass is enabled by defining CORE_REGS_SB_BYPASS_EN.
module core_regs_sb #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int NUM_RD        = 2,
  parameter bit HARDWIRE_ZERO = 1'b1
) (
  input logic           clk,
  input logic           rst,
  core_regs_sb_if.slave bus
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam int CNT_W    = ADDR_W + 1;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [CNT_W-1:0]    r_busy_cnt;

  logic                w_we0;
  logic                w_we1;
  logic                w_ready;
  logic                w_set;
  logic                w_dec0;
  logic                w_dec1;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [NUM_RD*DATA_W-1:0] w_rdata;
  logic [NUM_RD-1:0]   w_rbusy;

  // Effective write enables and issue acceptance; register 0 is never written nor marked busy when hardwired.
  always_comb begin
    w_we0   = bus.we0_in && !(HARDWIRE_ZERO && (bus.waddr0_in == {ADDR_W{1'b0}}));
    w_we1   = bus.we1_in && !(HARDWIRE_ZERO && (bus.waddr1_in == {ADDR_W{1'b0}}));
    w_ready = !r_busy[bus.issue_addr_in] ||
              (HARDWIRE_ZERO && (bus.issue_addr_in == {ADDR_W{1'b0}}));
    w_set   = bus.issue_in && w_ready &&
              !(HARDWIRE_ZERO && (bus.issue_addr_in == {ADDR_W{1'b0}}));
    w_dec0  = w_we0 && r_busy[bus.waddr0_in];
    w_dec1  = w_we1 && r_busy[bus.waddr1_in] && !(w_we0 && (bus.waddr0_in == bus.waddr1_in));
    w_cnt_nxt = r_busy_cnt + CNT_W'(w_set) - CNT_W'(w_dec0) - CNT_W'(w_dec1);
  end

  // Next busy vector: an accepted issue outranks a same-cycle writeback clear.
  always_comb begin
    w_busy_nxt = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_busy_nxt[k] = (w_set && (bus.issue_addr_in == ADDR_W'(k))) ? 1'b1 :
                      ((w_we0 && (bus.waddr0_in == ADDR_W'(k))) ||
                       (w_we1 && (bus.waddr1_in == ADDR_W'(k)))) ? 1'b0 : r_busy[k];
    end
  end

  // Read ports: stored data, optionally bypassed from this cycle's writes.
  always_comb begin
    w_rdata = '0;
    w_rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] w_ra;
      w_ra = bus.raddr_in[i*ADDR_W +: ADDR_W];
`ifdef CORE_REGS_SB_BYPASS_EN
      w_rdata[i*DATA_W +: DATA_W] =
        (HARDWIRE_ZERO && (w_ra == {ADDR_W{1'b0}})) ? {DATA_W{1'b0}} :
        (w_we1 && (bus.waddr1_in == w_ra)) ? bus.wdata1_in :
        (w_we0 && (bus.waddr0_in == w_ra)) ? bus.wdata0_in : r_regs[w_ra];
      w_rbusy[i] =
        (((w_we0 && (bus.waddr0_in == w_ra)) || (w_we1 && (bus.waddr1_in == w_ra))) &&
         !(w_set && (bus.issue_addr_in == w_ra))) ? 1'b0 : r_busy[w_ra];
`else
      w_rdata[i*DATA_W +: DATA_W] =
        (HARDWIRE_ZERO && (w_ra == {ADDR_W{1'b0}})) ? {DATA_W{1'b0}} : r_regs[w_ra];
      w_rbusy[i] = r_busy[w_ra];
`endif
    end
  end

  assign bus.rdata_out       = w_rdata;
  assign bus.rbusy_out       = w_rbusy;
  assign bus.issue_ready_out = w_ready;
  assign bus.busy_cnt_out    = r_busy_cnt;

  // Register storage; port 1 is applied last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      if (w_we0) begin
        r_regs[bus.waddr0_in] <= bus.wdata0_in;
      end
      if (w_we1) begin
        r_regs[bus.waddr1_in] <= bus.wdata1_in;
      end
    end
  end

  // Scoreboard state and its incrementally maintained population count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end
endmodule
